debug_snap_ctrl: RTL

DEBUG_SNAP_CTRL -- requirements
Module: debug_snap_ctrl

---
 rtl/debug_snap_pkg.sv | 14 +
 rtl/debug_snap_ctrl_if.sv | 29 ++
 rtl/debug_snap_bank.sv | 36 +++
 rtl/debug_snap_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/debug_snap_pkg.sv
// Shared constants and FSM state type for the debug snapshot controller.
package debug_snap_pkg;

    localparam int unsigned NREGS_DEF  = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W     = 5;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        SWAP
    } state_t;

endpackage

// File: rtl/debug_snap_ctrl_if.sv
// Shared register-file read port: CPU request/address in, arbitrated address out, read data back.
interface debug_snap_ctrl_if
    import debug_snap_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;

    // Controller side: arbitrates the read port and consumes the read data.
    modport master (
        input  cpu_req,
        input  cpu_addr,
        input  rf_data,
        output rf_addr
    );

    // Register-file / CPU side.
    modport slave (
        output cpu_req,
        output cpu_addr,
        output rf_data,
        input  rf_addr
    );

endinterface

// File: rtl/debug_snap_bank.sv
// Double-buffered snapshot storage: writes go to the back bank, reads come from the front bank.
module debug_snap_bank #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2][NREGS];
    logic              back;

    assign back  = ~sel;
    assign rdata = mem[sel][raddr];

    // Clear both banks on reset; otherwise write the back bank when requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < NREGS; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else if (we) begin
            mem[back][waddr] <= wdata;
        end
    end

endmodule

// File: rtl/debug_snap_ctrl.sv
// Copies the register file into a back bank on each vsync rising edge, stealing only
// the read-port cycles the CPU leaves idle, then swaps banks for the debug screen.
module debug_snap_ctrl
    import debug_snap_pkg::*;
#(
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vsync,
    input  logic                freeze,
    debug_snap_ctrl_if.master   rf,
    input  logic [ADDR_W-1:0]   scr_addr,
    output logic [DATA_W-1:0]   scr_data,
    output logic                busy,
    output logic                overrun,
    output logic [15:0]         frame_cnt
);

    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             front;
    logic             vsync_q;
    logic             v_rise;
    logic             copy_we;
    logic             start;

    assign v_rise     = vsync & ~vsync_q;
    assign start      = (state == IDLE) && v_rise && !freeze;
    assign rf.rf_addr = rf.cpu_req ? rf.cpu_addr : ADDR_W'(idx);

    // Next-state and per-cycle controls; the CPU always wins the read port.
    always_comb begin
        state_next = state;
        copy_we    = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = COPY;
            end
            COPY: begin
                busy = 1'b1;
                if (!rf.cpu_req) begin
                    copy_we = 1'b1;
                    if (idx == IDX_W'(NREGS - 1)) state_next = SWAP;
                end
            end
            SWAP: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Copy index: cleared on a new snapshot, advanced on each stolen cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          idx <= '0;
        else if (start)   idx <= '0;
        else if (copy_we) idx <= idx + 1'b1;
    end

    // Previous vsync for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vsync_q <= 1'b0;
        else     vsync_q <= vsync;
    end

    // Sticky overrun: an edge that lands while a snapshot is still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            overrun <= 1'b0;
        else if (v_rise && state != IDLE)   overrun <= 1'b1;
    end

    // Bank swap and frame counting at the end of each completed snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front     <= 1'b0;
            frame_cnt <= '0;
        end else if (state == SWAP) begin
            front     <= ~front;
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    debug_snap_bank #(
        .NREGS  (NREGS),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .sel   (front),
        .we    (copy_we),
        .waddr (idx),
        .wdata (rf.rf_data),
        .raddr (scr_addr[IDX_W-1:0]),
        .rdata (scr_data)
    );

endmodule
